rf_write_arbiter: RTL and testbench

// - Shares the single register-file write port between the in-order writeback stage and a long-latency

---
 rtl/mico_wb_pkg.sv | 21 ++
 rtl/wb_result_fifo.sv | 52 +++++
 rtl/rf_write_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mico_wb_pkg.sv
// Shared types for the register-file writeback path: a buffered multi-cycle result
// and the helper that turns a destination register into a scoreboard mask.
package mico_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Two-entry FIFO holding multi-cycle results until the RF write port is free.
// A push while full or a pop while empty is ignored, so the parent can never corrupt it.
module wb_result_fifo
  import mico_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  wb_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between pipe writeback (always wins) and buffered multi-cycle
// results; tracks multi-cycle destinations and requests a stall when a result starves.
module rf_write_arbiter #(
  parameter int XLEN         = mico_wb_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_rf_wb,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     pending,
  output logic            stall_req,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);
  import mico_wb_pkg::*;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic            pipe_win;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  wb_entry_t       push_entry;
  wb_entry_t       fifo_head;
  logic [SC_W-1:0] starve_cnt;
  logic [31:0]     pending_d;

  assign pipe_win        = wb_rf_wb && (wb_rd != 5'd0);
  assign mc_ready        = !fifo_full;
  assign push            = mc_valid && mc_ready;
  assign pop             = !pipe_win && !fifo_empty;
  assign push_entry.rd   = mc_rd;
  assign push_entry.data = mc_data;

  wb_result_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else if (pipe_win) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_rd;
      rf_wdata <= wb_data;
    end else if (pop) begin
      rf_we    <= (fifo_head.rd != 5'd0);
      rf_waddr <= fifo_head.rd;
      rf_wdata <= fifo_head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // stall_req rises on the edge the counter reaches STARVE_LIMIT and drops on the pop edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) begin
        stall_req <= 1'b1;
      end
    end
  end

  // Clear before set so a same-cycle reissue of a retiring rd keeps its pending bit.
  always_comb begin
    pending_d = pending;
    if (pop) begin
      pending_d = pending_d & ~rd_onehot(fifo_head.rd);
    end
    if (issue_valid) begin
      pending_d = pending_d | rd_onehot(issue_rd);
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

  // Interlocks owned by the issue stage; reissue is legal only as the old owner retires.
  a_no_issue_to_pending : assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid && issue_rd != 5'd0) |->
      (!pending[issue_rd] || (pop && fifo_head.rd == issue_rd)));

  a_no_pipe_to_pending : assert property (@(posedge clk) disable iff (!rst_n)
    pipe_win |-> !pending[wb_rd]);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: vector table for pipe writes, queue scoreboard of buffered
// multi-cycle results, and hand sequences for contention, starvation, collision and reset.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_rf_wb;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] pending;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  rf_write_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_rf_wb    (wb_rf_wb),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pending     (pending),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        mq[$];
  logic [31:0] m_pend;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = '0;
    m_addr = '0;
    m_data = '0;
    m_acc  = 1'b0;
  endtask

  task automatic idle_inputs();
    wb_rf_wb    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    mc_valid    = 1'b0;
    mc_rd       = '0;
    mc_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  // One clock: predict from the driven inputs, advance past the edge, compare.
  task automatic cycle();
    logic pipe;
    logic we_e;
    ent_t e;
    pipe = wb_rf_wb && (wb_rd != 5'd0);
    chk("mc_ready", mc_ready, mq.size() < 2);
    m_acc = mc_valid && (mq.size() < 2);
    we_e  = 1'b0;
    if (pipe) begin
      we_e   = 1'b1;
      m_addr = wb_rd;
      m_data = wb_data;
    end else if (mq.size() > 0) begin
      e      = mq.pop_front();
      we_e   = (e.rd != 5'd0);
      m_addr = e.rd;
      m_data = e.data;
      if (e.rd != 5'd0) m_pend[e.rd] = 1'b0;
    end
    if (m_acc) mq.push_back(ent_t'{rd: mc_rd, data: mc_data});
    if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, we_e);
    chk("rf_waddr", rf_waddr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    chk("pending", pending, m_pend);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[6];
    ent_t       src[3];
    int         idx;
    logic [4:0] got[$];

    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[2] = '{1'b0, 5'd7,  32'h22222222, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
    vt[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
    vt[5] = '{1'b0, 5'd1,  32'hFFFFFFFF, 1'b0, 5'd1,  32'h00000000};

    // reset held with activity on every input
    rst_n       = 1'b0;
    wb_rf_wb    = 1'b1;
    wb_rd       = 5'd5;
    wb_data     = 32'h55;
    mc_valid    = 1'b1;
    mc_rd       = 5'd4;
    mc_data     = 32'h44;
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_pending", pending, 0);
    chk("rst_stall", stall_req, 0);
    idle_inputs();
    rst_n = 1'b1;
    chk("rst_mc_ready", mc_ready, 1);
    cycle();
    cycle();

    for (int i = 0; i < 6; i++) begin
      wb_rf_wb = vt[i].wb;
      wb_rd    = vt[i].rd;
      wb_data  = vt[i].data;
      cycle();
      chk("vec_we", rf_we, vt[i].exp_we);
      chk("vec_addr", rf_waddr, vt[i].exp_addr);
      chk("vec_data", rf_wdata, vt[i].exp_data);
    end
    idle_inputs();

    // multi-cycle path: issue, push, pop two cycles after push request
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    cycle();
    chk("mc_pend7_set", pending[7], 1);
    issue_valid = 1'b0;
    mc_valid    = 1'b1;
    mc_rd       = 5'd7;
    mc_data     = 32'h12;
    cycle();
    chk("mc_no_bypass", rf_we, 0);
    mc_valid = 1'b0;
    cycle();
    chk("mc_we", rf_we, 1);
    chk("mc_addr", rf_waddr, 7);
    chk("mc_data", rf_wdata, 32'h12);
    chk("mc_pend7_clr", pending[7], 0);

    // contention: pipe busy for 6 cycles while three results queue up
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(20 + i);
      cycle();
    end
    issue_valid = 1'b0;
    src[0] = ent_t'{rd: 5'd20, data: 32'hC0};
    src[1] = ent_t'{rd: 5'd21, data: 32'hC1};
    src[2] = ent_t'{rd: 5'd22, data: 32'hC2};
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      wb_rf_wb = (i < 6);
      wb_rd    = (i < 6) ? 5'(10 + i) : 5'd0;
      wb_data  = 32'h100 + 32'(i);
      mc_valid = (idx < 3);
      mc_rd    = (idx < 3) ? src[idx].rd : 5'd0;
      mc_data  = (idx < 3) ? src[idx].data : 32'd0;
      if (i == 2) chk("cont_full", mc_ready, 0);
      cycle();
      if (m_acc) idx++;
      if (i >= 6 && rf_we) got.push_back(rf_waddr);
    end
    idle_inputs();
    chk("cont_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("cont_order0", got[0], 20);
      chk("cont_order1", got[1], 21);
      chk("cont_order2", got[2], 22);
    end
    chk("cont_pend_clr", pending, 0);

    // starvation: one buffered result blocked by a pipe write every cycle
    wb_rf_wb = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'h33;
    mc_valid = 1'b1;
    mc_rd    = 5'd8;
    mc_data  = 32'h88;
    cycle();
    chk("starve_0", stall_req, 0);
    mc_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wb_data = 32'h330 + 32'(i);
      cycle();
      chk($sformatf("starve_%0d", i), stall_req, (i >= 4));
    end
    wb_rf_wb = 1'b0;
    cycle();
    chk("starve_pop_we", rf_we, 1);
    chk("starve_pop_addr", rf_waddr, 8);
    chk("starve_release", stall_req, 0);
    idle_inputs();

    // set/clear collision on rd 9
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    cycle();
    issue_valid = 1'b0;
    mc_valid    = 1'b1;
    mc_rd       = 5'd9;
    mc_data     = 32'h99;
    cycle();
    mc_valid    = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    cycle();
    chk("coll_we", rf_we, 1);
    chk("coll_addr", rf_waddr, 9);
    chk("coll_pend9", pending[9], 1);
    issue_valid = 1'b0;
    mc_valid    = 1'b1;
    mc_data     = 32'h9A;
    cycle();
    mc_valid = 1'b0;
    cycle();
    chk("coll_pend9_clr", pending[9], 0);

    // reset mid-operation discards the buffer and the scoreboard
    wb_rf_wb    = 1'b1;
    wb_rd       = 5'd11;
    wb_data     = 32'hB0;
    issue_valid = 1'b1;
    issue_rd    = 5'd19;
    mc_valid    = 1'b1;
    mc_rd       = 5'd17;
    mc_data     = 32'h17;
    cycle();
    issue_valid = 1'b0;
    mc_rd       = 5'd18;
    mc_data     = 32'h18;
    cycle();
    chk("mid_full", mc_ready, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_addr", rf_waddr, 0);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_stall", stall_req, 0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_discard", rf_we, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
